// File: rtl/ram_sp_param.sv
// rtl/ram_sp_param.sv - Parametrised single-port synchronous RAM with clear sweep
//
// Single-port scratch RAM with registered read data and a configurable read latency.
// Reset and clr_req do not clear the array in one cycle. Instead a sweep zeroes one
// word per cycle, which lets the storage array map onto block RAM.
//
// Parameters:
//   DATA_W     - data word width in bits
//   ADDR_W     - address width; the array holds 2**ADDR_W words
//   RD_LAT     - read latency in cycles (1 or 2)
//   WRITE_MODE - what data_out shows on a write:
//                0 = the new data, 1 = the old word, 2 = unchanged
//
// Ports:
//   clk      - clock; all logic runs on the rising edge
//   rst      - synchronous active-high reset; starts a clear sweep
//   csn      - chip select, active-low
//   rwn      - 1 = read, 0 = write; only used when an access is accepted
//   addr     - word address
//   data_in  - write data
//   clr_req  - one-cycle request to clear the whole array to zero
//   data_out - registered read data; holds its value between updates
//   rd_valid - one-cycle pulse with each data_out update
//   busy     - high while the clear sweep runs; accesses are ignored then

module ram_sp_param #(
   parameter int DATA_W     = 4,
   parameter int ADDR_W     = 4,
   parameter int RD_LAT     = 1,
   parameter int WRITE_MODE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              csn,
   input  logic              rwn,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              clr_req,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              busy
);

   localparam int                DEPTH     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] clr_ptr;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              acc_ok;
   logic              acc_wr;
   logic              acc_rd;
   logic [DATA_W-1:0] rd_word;
   logic              s1_load;
   logic [DATA_W-1:0] s1_word;
   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;

   // ------------------------------------------------------------------
   // Clear-sweep FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_CLEAR;
      end else begin
         state <= state_nxt;
      end
   end

   // The pointer sits at zero in IDLE, so entering CLEAR always starts at word 0.
   // At the end of a sweep it rolls over from LAST_ADDR back to zero by itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         clr_ptr <= '0;
      end else if (state == ST_IDLE) begin
         clr_ptr <= '0;
      end else begin
         clr_ptr <= clr_ptr + ADDR_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Clear-sweep FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (clr_req) begin
               state_nxt = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            // Leave on the same edge that zeroes the last word.
            if (clr_ptr == LAST_ADDR) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_CLEAR;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Clear-sweep FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      busy = (state == ST_CLEAR);
   end

   // ------------------------------------------------------------------
   // Access decode
   // ------------------------------------------------------------------
   // busy only reflects the registered state. An access in the same cycle as
   // clr_req is therefore still accepted, and the sweep starts one cycle later.
   // An access during the reset cycle is dropped because the pipeline is being
   // flushed.
   assign acc_ok = !csn && !busy && !rst;
   assign acc_wr = acc_ok && !rwn;
   assign acc_rd = acc_ok && rwn;

   // ------------------------------------------------------------------
   // Storage array
   // ------------------------------------------------------------------
   // The sweep write and the user write can never collide, because user
   // accesses are blocked while busy is high.
   always_ff @(posedge clk) begin
      if (!rst && busy) begin
         mem[clr_ptr] <= '0;
      end else if (acc_wr) begin
         mem[addr] <= data_in;
      end
   end

   // This is the word before the current edge's write, which gives the
   // read-first value.
   assign rd_word = mem[addr];

   // ------------------------------------------------------------------
   // Read pipeline, first stage
   // ------------------------------------------------------------------
   assign s1_load = acc_rd || (acc_wr && (WRITE_MODE != 2));
   assign s1_word = (acc_wr && (WRITE_MODE == 0)) ? data_in : rd_word;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= s1_load;
         // Data is only captured with a valid entry, so it holds between updates.
         if (s1_load) begin
            s1_data <= s1_word;
         end
      end
   end

   // ------------------------------------------------------------------
   // Output latency selection
   // ------------------------------------------------------------------
   generate
      if (RD_LAT == 1) begin : g_lat1
         assign data_out = s1_data;
         assign rd_valid = s1_valid;
      end else if (RD_LAT == 2) begin : g_lat2
         logic              s2_valid;
         logic [DATA_W-1:0] s2_data;

         always_ff @(posedge clk) begin
            if (rst) begin
               s2_valid <= 1'b0;
               s2_data  <= '0;
            end else begin
               s2_valid <= s1_valid;
               if (s1_valid) begin
                  s2_data <= s1_data;
               end
            end
         end

         assign data_out = s2_data;
         assign rd_valid = s2_valid;
      end else begin : g_bad_lat
         $error("ram_sp_param: RD_LAT must be 1 or 2");
      end
   endgenerate

   generate
      if ((WRITE_MODE < 0) || (WRITE_MODE > 2)) begin : g_bad_mode
         $error("ram_sp_param: WRITE_MODE must be 0, 1 or 2");
      end
   endgenerate

endmodule

// File: tb/tb_ram_sp_param.sv
// tb/tb_ram_sp_param.sv - Directed self-checking bench for ram_sp_param

module tb_ram_sp_param;

   logic       clk;
   logic       rst;

   // Shared stimulus for the three 4x16 instances (write modes 0, 1 and 2).
   logic       csn;
   logic       rwn;
   logic       clr_req;
   logic [3:0] addr;
   logic [3:0] din;
   logic [3:0] dout0, dout1, dout2;
   logic       v0, v1, v2;
   logic       busy0, busy1, busy2;

   // Stimulus for the 8-bit, 64-word, two-cycle latency instance.
   logic       csn8;
   logic       rwn8;
   logic       clr8;
   logic [5:0] addr8;
   logic [7:0] din8;
   logic [7:0] dout8;
   logic       v8;
   logic       busy8;

   int n_checks = 0;
   int n_errors = 0;
   int c0;
   int c8;
   int guard;

   ram_sp_param u_m0 (
      .clk(clk), .rst(rst), .csn(csn), .rwn(rwn), .addr(addr), .data_in(din),
      .clr_req(clr_req), .data_out(dout0), .rd_valid(v0), .busy(busy0)
   );

   ram_sp_param #(.WRITE_MODE(1)) u_m1 (
      .clk(clk), .rst(rst), .csn(csn), .rwn(rwn), .addr(addr), .data_in(din),
      .clr_req(clr_req), .data_out(dout1), .rd_valid(v1), .busy(busy1)
   );

   ram_sp_param #(.WRITE_MODE(2)) u_m2 (
      .clk(clk), .rst(rst), .csn(csn), .rwn(rwn), .addr(addr), .data_in(din),
      .clr_req(clr_req), .data_out(dout2), .rd_valid(v2), .busy(busy2)
   );

   ram_sp_param #(.DATA_W(8), .ADDR_W(6), .RD_LAT(2)) u_l2 (
      .clk(clk), .rst(rst), .csn(csn8), .rwn(rwn8), .addr(addr8), .data_in(din8),
      .clr_req(clr8), .data_out(dout8), .rd_valid(v8), .busy(busy8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Count the cycles each sweep stays busy, with a bounded wait.
   task automatic count_busy();
      c0 = 0;
      c8 = 0;
      guard = 0;
      while ((busy0 || busy8) && guard < 200) begin
         if (busy0) c0++;
         if (busy8) c8++;
         guard++;
         cycle();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; csn = 1'b1; rwn = 1'b1; clr_req = 1'b0; addr = '0; din = '0;
      csn8 = 1'b1; rwn8 = 1'b1; clr8 = 1'b0; addr8 = '0; din8 = '0;

      // Reset state and the sweep that follows the reset release.
      cycle();
      cycle();
      check("rst_busy", busy0, 1);
      check("rst_dout", dout0, 0);
      check("rst_valid", v0, 0);
      check("rst_busy_l2", busy8, 1);
      rst = 1'b0;
      count_busy();
      check("sweep_len", c0, 16);
      check("sweep_len_l2", c8, 64);
      check("sweep_done_m1", busy1, 0);
      check("sweep_done_m2", busy2, 0);

      csn = 1'b0; rwn = 1'b1; addr = 4'd7;
      cycle();
      check("rd_after_rst_d", dout0, 0);
      check("rd_after_rst_v", v0, 1);

      // Write-through, read-first and no-change writes to the same word.
      rwn = 1'b0; addr = 4'd3; din = 4'hA;
      cycle();
      check("wr_thru_d", dout0, 4'hA);
      check("wr_thru_v", v0, 1);
      check("wr_rdfirst_d", dout1, 0);
      check("wr_rdfirst_v", v1, 1);
      check("wr_nochg_v", v2, 0);
      rwn = 1'b1;
      cycle();
      check("rd3_d", dout0, 4'hA);
      check("rd3_v", v0, 1);
      check("rd3_m1_d", dout1, 4'hA);
      csn = 1'b1;
      cycle();
      check("idle_v", v0, 0);
      check("idle_hold", dout0, 4'hA);

      csn = 1'b0; rwn = 1'b0; addr = 4'd5; din = 4'h6;
      cycle();
      din = 4'h9;
      cycle();
      check("wm0_d", dout0, 4'h9);
      check("wm1_old_d", dout1, 4'h6);
      check("wm1_v", v1, 1);
      check("wm2_hold_d", dout2, 4'hA);
      check("wm2_v", v2, 0);
      rwn = 1'b1;
      cycle();
      check("raw_m0", dout0, 4'h9);
      check("raw_m1", dout1, 4'h9);
      check("raw_m2", dout2, 4'h9);
      check("raw_m2_v", v2, 1);
      csn = 1'b1;

      // Two-cycle latency instance: back-to-back writes, then reads.
      csn8 = 1'b0; rwn8 = 1'b0; addr8 = 6'd0; din8 = 8'h11;
      cycle();
      check("l2_wr_lat", v8, 0);
      addr8 = 6'd1; din8 = 8'h22;
      cycle();
      check("l2_wr0_v", v8, 1);
      check("l2_wr0_d", dout8, 8'h11);
      addr8 = 6'd2; din8 = 8'h33;
      cycle();
      check("l2_wr1_d", dout8, 8'h22);
      csn8 = 1'b1;
      cycle();
      check("l2_wr2_d", dout8, 8'h33);
      cycle();
      check("l2_drain_v", v8, 0);
      csn8 = 1'b0; rwn8 = 1'b1; addr8 = 6'd0;
      cycle();
      check("l2_rd_lat", v8, 0);
      addr8 = 6'd1;
      cycle();
      check("l2_rd0_v", v8, 1);
      check("l2_rd0_d", dout8, 8'h11);
      addr8 = 6'd2;
      cycle();
      check("l2_rd1_v", v8, 1);
      check("l2_rd1_d", dout8, 8'h22);
      csn8 = 1'b1;
      cycle();
      check("l2_rd2_v", v8, 1);
      check("l2_rd2_d", dout8, 8'h33);
      cycle();
      check("l2_end_v", v8, 0);
      check("l2_end_hold", dout8, 8'h33);

      // clr_req together with a write: the write lands, then the sweep wipes all.
      csn = 1'b0; rwn = 1'b0; addr = 4'd2; din = 4'h7; clr_req = 1'b1;
      cycle();
      check("clr_wr_d", dout0, 4'h7);
      check("clr_wr_v", v0, 1);
      check("clr_busy", busy0, 1);
      clr_req = 1'b0; addr = 4'd4; din = 4'hF;
      count_busy();
      check("clr_len", c0, 16);
      check("clr_busy_v", v0, 0);
      rwn = 1'b1;
      for (int i = 0; i < 16; i++) begin
         addr = 4'(i);
         cycle();
         check("clr_read", dout0, 0);
      end
      check("clr_read_v", v0, 1);

      // Reset in the middle of a sweep restarts it from word 0.
      rwn = 1'b0; addr = 4'd1; din = 4'hC; clr_req = 1'b1;
      cycle();
      check("pre_rst_d", dout0, 4'hC);
      clr_req = 1'b0; csn = 1'b1;
      repeat (8) cycle();
      rst = 1'b1;
      cycle();
      check("mid_rst_d", dout0, 0);
      check("mid_rst_v", v0, 0);
      check("mid_rst_busy", busy0, 1);
      check("mid_rst_m1_d", dout1, 0);
      rst = 1'b0;
      count_busy();
      check("restart_len", c0, 16);
      check("restart_len_l2", c8, 64);
      csn = 1'b0; rwn = 1'b1; addr = 4'd5;
      cycle();
      check("post_rst_rd_d", dout0, 0);
      check("post_rst_rd_v", v0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
